ifetch_unit: RTL

Instruction-fetch sequencer between the program counter register and instruction memory. It takes the current PC on request and runs a req/ack transaction on the instruction-memory port. It returns the fetched word with its PC to the decode stage through a valid/ready handshake. It also handles misaligned PCs, branch flushes and memory time-outs.

---
 rtl/ifetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: launches one imem req/ack transaction per
// fetch request. It returns the fetched word and its PC to decode through
// a valid/ready handshake. It also handles misaligned PCs, branch flushes
// and memory time-outs.
module ifetch_unit #(
  parameter int N       = 32,
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc_in,
  input  logic         fetch_req,
  input  logic         flush,
  input  logic         instr_ready,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] instr_out,
  output logic [N-1:0] instr_pc,
  output logic         instr_valid,
  output logic         busy,
  output logic         misalign,
  output logic         timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t        state;
  logic          drop;
  logic [CW-1:0] wait_cnt;

  logic aligned;
  logic launch;
  logic bad_pc;

  // Decode the incoming fetch request; a flush suppresses both outcomes.
  always_comb begin
    aligned = (pc_in[1:0] == 2'b00);
    launch  = fetch_req & ~flush & aligned;
    bad_pc  = fetch_req & ~flush & ~aligned;
  end

  // Fetch sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drop        <= 1'b0;
      wait_cnt    <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            state     <= REQ;
          end else if (bad_pc) begin
            misalign <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            // Ack wins over a simultaneous time-out.
            instr_out <= imem_rdata;
            instr_pc  <= imem_addr;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              instr_valid <= 1'b1;
              state       <= VALID;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            drop        <= 1'b0;
            state       <= IDLE;
          end else begin
            // A flush cannot abandon the bus cycle; remember to discard it.
            wait_cnt <= wait_cnt + 1'b1;
            if (flush) begin
              drop <= 1'b1;
            end
          end
        end
        VALID: begin
          if (flush) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (launch) begin
              imem_addr <= pc_in;
              imem_req  <= 1'b1;
              busy      <= 1'b1;
              wait_cnt  <= '0;
              state     <= REQ;
            end else begin
              if (bad_pc) begin
                misalign <= 1'b1;
              end
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
